serial_mag_cmp: RTL and testbench

//  Downstream stage of the registered 1-bit comparator. Consumes its per-bit g/e/l stream,
//  MSB first, over WIDTH accepted bits and produces the multi-bit magnitude result
//  (greater/equal/less), the index of the first differing bit, and an error flag.

---
 rtl/serial_mag_cmp_pkg.sv | 18 +
 rtl/bit_cnt_down.sv | 40 ++++
 rtl/serial_mag_cmp.sv | 164 ++++++++++++++++
 tb/tb_serial_mag_cmp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: state encoding,
// default operand width and the one-hot check on a {g,e,l} bit triple.
package serial_mag_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when exactly one of g/e/l is asserted.
  function automatic logic onehot3(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

endpackage

// File: rtl/bit_cnt_down.sv
// Loadable down-counter with enable and zero flag; saturates at zero so the
// bit index never wraps past the final bit.
module bit_cnt_down #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_mag_cmp.sv
// Serial magnitude comparator: folds an MSB-first stream of per-bit g/e/l
// flags into a multi-bit greater/equal/less result, first-difference index
// and error flag, offered to the consumer with a valid/ready handshake.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for start; last result held on outputs
//  ST_RUN  | accepting bits on bit_vld, cnt = index of the next bit
//  ST_DONE | result valid, held until res_rdy
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            bit_vld,
  input  logic            g_in,
  input  logic            e_in,
  input  logic            l_in,
  input  logic            res_rdy,
  output logic            busy,
  output logic            res_vld,
  output logic            res_g,
  output logic            res_e,
  output logic            res_l,
  output logic            res_err,
  output logic [IDXW-1:0] diff_idx
);

  state_e            state_q, state_d;
  logic              decided_q, decided_d;
  logic              busy_q, busy_d;
  logic              res_vld_q, res_vld_d;
  logic              res_g_q, res_g_d;
  logic              res_e_q, res_e_d;
  logic              res_l_q, res_l_d;
  logic              res_err_q, res_err_d;
  logic [IDXW-1:0]   diff_idx_q, diff_idx_d;

  logic              cnt_load;
  logic              cnt_en;
  logic [IDXW-1:0]   cnt;
  logic              cnt_zero;
  logic              bit_ok;

  assign bit_ok = onehot3(g_in, e_in, l_in);

  bit_cnt_down #(.W(IDXW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (IDXW'(WIDTH - 1)),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next-state, decision and error logic; results only move in RUN or on a new start.
  always_comb begin
    state_d    = state_q;
    decided_d  = decided_q;
    busy_d     = busy_q;
    res_vld_d  = res_vld_q;
    res_g_d    = res_g_q;
    res_e_d    = res_e_q;
    res_l_d    = res_l_q;
    res_err_d  = res_err_q;
    diff_idx_d = diff_idx_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (bit_vld) begin
          cnt_en = 1'b1;
          if (!bit_ok) begin
            res_err_d = 1'b1;
          end else if (!decided_q && (g_in || l_in)) begin
            decided_d  = 1'b1;
            res_g_d    = g_in;
            res_l_d    = l_in;
            diff_idx_d = cnt;
          end
          if (cnt_zero) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            res_vld_d = 1'b1;
            res_e_d   = !decided_d && !res_err_d;
          end
        end
      end
      ST_DONE: begin
        if (res_rdy) begin
          res_vld_d = 1'b0;
          if (start) begin
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        res_vld_d = 1'b0;
      end
    endcase

    // A new compare clears the previous result in both IDLE and DONE.
    if (cnt_load) begin
      state_d    = ST_RUN;
      busy_d     = 1'b1;
      res_vld_d  = 1'b0;
      decided_d  = 1'b0;
      res_g_d    = 1'b0;
      res_e_d    = 1'b0;
      res_l_d    = 1'b0;
      res_err_d  = 1'b0;
      diff_idx_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      decided_q  <= 1'b0;
      busy_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_g_q    <= 1'b0;
      res_e_q    <= 1'b0;
      res_l_q    <= 1'b0;
      res_err_q  <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      decided_q  <= decided_d;
      busy_q     <= busy_d;
      res_vld_q  <= res_vld_d;
      res_g_q    <= res_g_d;
      res_e_q    <= res_e_d;
      res_l_q    <= res_l_d;
      res_err_q  <= res_err_d;
      diff_idx_q <= diff_idx_d;
    end
  end

  assign busy     = busy_q;
  assign res_vld  = res_vld_q;
  assign res_g    = res_g_q;
  assign res_e    = res_e_q;
  assign res_l    = res_l_q;
  assign res_err  = res_err_q;
  assign diff_idx = diff_idx_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed bench for serial_mag_cmp at WIDTH=4 with an expected-result queue.
module tb_serial_mag_cmp;

  localparam int WIDTH = 4;
  localparam int IDXW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            bit_vld = 1'b0;
  logic            g_in = 1'b0;
  logic            e_in = 1'b0;
  logic            l_in = 1'b0;
  logic            res_rdy = 1'b0;
  logic            busy;
  logic            res_vld;
  logic            res_g;
  logic            res_e;
  logic            res_l;
  logic            res_err;
  logic [IDXW-1:0] diff_idx;

  typedef struct packed {
    logic            g;
    logic            e;
    logic            l;
    logic            err;
    logic [IDXW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [2:0] B_G = 3'b100;
  localparam logic [2:0] B_E = 3'b010;
  localparam logic [2:0] B_L = 3'b001;

  serial_mag_cmp #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_vld  (bit_vld),
    .g_in     (g_in),
    .e_in     (e_in),
    .l_in     (l_in),
    .res_rdy  (res_rdy),
    .busy     (busy),
    .res_vld  (res_vld),
    .res_g    (res_g),
    .res_e    (res_e),
    .res_l    (res_l),
    .res_err  (res_err),
    .diff_idx (diff_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bits packed MSB-first as {g,e,l} triples in bits[11:0].
  function automatic exp_t model(input logic [11:0] bits);
    exp_t r;
    logic decided;
    logic [2:0] b;
    r = '0;
    decided = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      b = bits[11 - 3*i -: 3];
      if ((b != B_G) && (b != B_E) && (b != B_L)) begin
        r.err = 1'b1;
      end else if (!decided && (b != B_E)) begin
        decided = 1'b1;
        r.g   = b[2];
        r.l   = b[0];
        r.idx = IDXW'(WIDTH - 1 - i);
      end
    end
    r.e = !decided && !r.err;
    return r;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic [2:0] b, input int gap);
    {g_in, e_in, l_in} = b;
    bit_vld = 1'b1;
    @(negedge clk);
    bit_vld = 1'b0;
    {g_in, e_in, l_in} = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  // Feeds all bits; the final bit has no trailing gap so the result is due now.
  task automatic feed(input logic [11:0] bits, input int gap);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(bits[11 - 3*i -: 3], (i == WIDTH - 1) ? 0 : gap);
    end
    exp_q.push_back(model(bits));
  endtask

  task automatic wait_result(input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    while (!res_vld && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, 8'(waited), 8'd0);
    check({tag, "_vld"}, {7'd0, res_vld}, 8'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_g"}, {7'd0, res_g}, {7'd0, e.g});
      check({tag, "_e"}, {7'd0, res_e}, {7'd0, e.e});
      check({tag, "_l"}, {7'd0, res_l}, {7'd0, e.l});
      check({tag, "_err"}, {7'd0, res_err}, {7'd0, e.err});
      check({tag, "_idx"}, 8'(diff_idx), 8'(e.idx));
    end
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  task automatic accept(input string tag);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    check({tag, "_vld_drop"}, {7'd0, res_vld}, 8'd0);
    check({tag, "_idle"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", {1'b0, busy, res_vld, res_g, res_e, res_l, res_err, 1'b0}, 8'd0);
    check("rst_idx", 8'(diff_idx), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all equal
    do_start();
    check("t1_busy", {7'd0, busy}, 8'd1);
    feed({B_E, B_E, B_E, B_E}, 0);
    wait_result("t1");
    accept("t1");

    // 2: decided at bit 1, later l ignored
    do_start();
    feed({B_E, B_E, B_G, B_L}, 0);
    wait_result("t2");
    accept("t2");

    // 3: gaps, start ignored in RUN, consumer back-pressure
    do_start();
    send_bit(B_L, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bit(B_G, 2);
    send_bit(B_G, 2);
    send_bit(B_G, 0);
    exp_q.push_back(model({B_L, B_G, B_G, B_G}));
    wait_result("t3");
    bit_vld = 1'b1;
    {g_in, e_in, l_in} = B_G;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_vld", {7'd0, res_vld}, 8'd1);
      check("t3_hold_res", {4'd0, res_g, res_e, res_l, res_err}, 8'b0010);
      check("t3_hold_idx", 8'(diff_idx), 8'd3);
    end
    bit_vld = 1'b0;
    {g_in, e_in, l_in} = 3'b000;
    accept("t3");
    check("t3_res_kept", {4'd0, res_g, res_e, res_l, res_err}, 8'b0010);
    check("t3_idx_kept", 8'(diff_idx), 8'd3);

    // 4: non-one-hot bit sets sticky error and never decides
    do_start();
    feed({B_E, 3'b110, B_E, B_E}, 0);
    wait_result("t4");
    accept("t4");
    do_start();
    check("t4_err_clr", {7'd0, res_err}, 8'd0);
    feed({B_E, B_E, B_E, B_L}, 0);
    wait_result("t4b");
    accept("t4b");

    // 5: async reset mid-compare
    do_start();
    send_bit(B_G, 0);
    send_bit(B_E, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async", {1'b0, busy, res_vld, res_g, res_e, res_l, res_err, 1'b0}, 8'd0);
    check("t5_idx", 8'(diff_idx), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle", {7'd0, busy}, 8'd0);
    do_start();
    feed({B_E, B_E, B_E, B_E}, 0);
    wait_result("t5");
    accept("t5");

    // 6: back-to-back start from DONE
    do_start();
    feed({B_L, B_E, B_E, B_E}, 0);
    wait_result("t6a");
    res_rdy = 1'b1;
    start = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    start = 1'b0;
    check("t6_busy", {7'd0, busy}, 8'd1);
    check("t6_vld", {7'd0, res_vld}, 8'd0);
    check("t6_clr", {4'd0, res_g, res_e, res_l, res_err}, 8'd0);
    check("t6_idx_clr", 8'(diff_idx), 8'd0);
    feed({B_G, B_E, B_E, B_E}, 0);
    wait_result("t6b");
    accept("t6b");

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
